// File: rtl/reg_writeback_ctrl_if.sv
// reg_writeback_ctrl_if: bundles the result, issue, hazard-query and write-port signals of
// reg_writeback_ctrl.
//   master : producer side (drives ALU/load results, issue info and operand queries;
//            observes lu_ready, busy flags, write port, forwarding and fifo_count)
//   slave  : the writeback controller
// Parameters: FIFO_DEPTH (load-result queue entries), DATA_W (result width).
interface reg_writeback_ctrl_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lu_valid;
    logic [4:0]        lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wb_write;
    logic              wb_hit;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rs1_fwd_valid;
    logic [DATA_W-1:0] rs1_fwd_data;
    logic              rs2_fwd_valid;
    logic [DATA_W-1:0] rs2_fwd_data;
    logic [CntW-1:0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        output iss_valid, iss_rd,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  wb_write, wb_hit, wb_addr, wb_data,
        input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        input  fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        input  iss_valid, iss_rd,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output wb_write, wb_hit, wb_addr, wb_data,
        output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        output fifo_count
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates a single register-file write port between a single-cycle
// ALU result (priority) and a queue of long-latency load results, and keeps a scoreboard of
// registers with outstanding writes for hazard queries.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RESET : synchronous, active-high reset
//   bus   : reg_writeback_ctrl_if.slave (ALU/load results, issue, rs queries, write port,
//           forwarding, fifo_count)
// Build option: define WB_FWD_EN to enable write-port forwarding to rs1/rs2; otherwise the
// forwarding outputs are tied to zero.
module reg_writeback_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32
) (
    input logic                 CLK,
    input logic                 RESET,
    reg_writeback_ctrl_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    logic [4:0]        mem_rd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       pending_q, pending_d;  // bit 0 is never set
    logic              wb_write_q, wb_write_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              lu_ready;
    logic              push;
    logic              pop;
    logic              alu_sel;

    // A full queue refuses even if it pops this edge; keeps the ready path off the pop logic.
    assign lu_ready = !RESET && (count_q < DepthC);
    // rd=0 loads complete the handshake but are dropped.
    assign push     = bus.lu_valid && lu_ready && (bus.lu_rd != 5'd0);
    assign alu_sel  = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop      = !alu_sel && (count_q != '0);

    always_comb begin
        wb_write_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (alu_sel) begin
            wb_write_d = 1'b1;
            wb_addr_d  = bus.alu_rd;
            wb_data_d  = bus.alu_data;
        end else if (pop) begin
            wb_write_d = 1'b1;
            wb_addr_d  = mem_rd_q[rd_ptr_q];
            wb_data_d  = mem_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set is applied after clear so a same-edge re-issue keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_write_d) begin
            pending_d[wb_addr_d] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            pending_q  <= pending_d;
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= bus.lu_rd;
            mem_data_q[wr_ptr_q] <= bus.lu_data;
        end
    end

    assign bus.lu_ready   = lu_ready;
    assign bus.fifo_count = count_q;
    assign bus.wb_write   = wb_write_q;
    assign bus.wb_hit     = wb_write_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.rs1_busy   = (bus.rs1_addr != 5'd0) && pending_q[bus.rs1_addr];
    assign bus.rs2_busy   = (bus.rs2_addr != 5'd0) && pending_q[bus.rs2_addr];

`ifdef WB_FWD_EN
    assign bus.rs1_fwd_valid = wb_write_q && (wb_addr_q == bus.rs1_addr) &&
                               (bus.rs1_addr != 5'd0);
    assign bus.rs1_fwd_data  = wb_data_q;
    assign bus.rs2_fwd_valid = wb_write_q && (wb_addr_q == bus.rs2_addr) &&
                               (bus.rs2_addr != 5'd0);
    assign bus.rs2_fwd_data  = wb_data_q;
`else
    assign bus.rs1_fwd_valid = 1'b0;
    assign bus.rs1_fwd_data  = '0;
    assign bus.rs2_fwd_valid = 1'b0;
    assign bus.rs2_fwd_data  = '0;
`endif
endmodule
